// File: rtl/bp_cce_inst_ram_loader_if.sv
// Boot-ROM read port and config-link request/readback bundle of the CCE instruction RAM loader.
interface bp_cce_inst_ram_loader_if #(
    parameter int inst_ram_els_p        = 4,
    parameter int inst_width_p          = 48,
    parameter int cfg_link_addr_width_p = 16,
    parameter int cfg_link_data_width_p = 32
);
    localparam int inst_addr_width_lp =
        (inst_ram_els_p == 1) ? 1 : $clog2(inst_ram_els_p);

    logic [inst_addr_width_lp-1:0]      rom_addr_o;
    logic                               rom_v_o;
    logic [inst_width_p-1:0]            rom_data_i;

    logic [cfg_link_addr_width_p-2:0]   config_addr_o;
    logic [cfg_link_data_width_p-1:0]   config_data_o;
    logic                               config_v_o;
    logic                               config_w_o;
    logic                               config_ready_i;

    logic [cfg_link_data_width_p-1:0]   config_data_i;
    logic                               config_v_i;
    logic                               config_ready_o;

    modport master (
        output rom_addr_o, rom_v_o,
        input  rom_data_i,
        output config_addr_o, config_data_o, config_v_o, config_w_o,
        input  config_ready_i,
        input  config_data_i, config_v_i,
        output config_ready_o
    );

    modport slave (
        input  rom_addr_o, rom_v_o,
        output rom_data_i,
        input  config_addr_o, config_data_o, config_v_o, config_w_o,
        output config_ready_i,
        output config_data_i, config_v_i,
        input  config_ready_o
    );
endinterface

// File: rtl/bp_cce_inst_ram_loader.sv
// Copies boot-ROM instructions into the CCE instruction RAM over the config link.
// Define BP_CCE_INST_RAM_LOADER_VERIFY_EN to read back and compare every entry.
module bp_cce_inst_ram_loader #(
    parameter int inst_ram_els_p        = 4,
    parameter int inst_width_p          = 48,
    parameter int cfg_link_addr_width_p = 16,
    parameter int cfg_link_data_width_p = 32
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    bp_cce_inst_ram_loader_if.master bus,
    output logic freeze_o,
    output logic done_o,
    output logic error_o
);
    localparam int inst_addr_width_lp =
        (inst_ram_els_p == 1) ? 1 : $clog2(inst_ram_els_p);
    localparam int hi_width_lp = inst_width_p - cfg_link_data_width_p;
    localparam int cfg_addr_w_lp = cfg_link_addr_width_p - 1;
    localparam logic [inst_addr_width_lp-1:0] last_idx_lp =
        inst_addr_width_lp'(inst_ram_els_p - 1);

    localparam logic [3:0] RESET   = 4'd0;
    localparam logic [3:0] IDLE    = 4'd1;
    localparam logic [3:0] ROM_RD  = 4'd2;
    localparam logic [3:0] ROM_CAP = 4'd3;
    localparam logic [3:0] WR_LO   = 4'd4;
    localparam logic [3:0] WR_HI   = 4'd5;
    localparam logic [3:0] NEXT    = 4'd6;
    localparam logic [3:0] DONE    = 4'd7;
    localparam logic [3:0] ERROR   = 4'd8;
`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
    localparam logic [3:0] RD_LO_REQ  = 4'd9;
    localparam logic [3:0] RD_LO_RESP = 4'd10;
    localparam logic [3:0] RD_HI_REQ  = 4'd11;
    localparam logic [3:0] RD_HI_RESP = 4'd12;
`endif

    logic [3:0]                    state_r, state_n;
    logic [inst_addr_width_lp-1:0] idx_r;
    logic [inst_width_p-1:0]       inst_r;

    logic [cfg_link_data_width_p-1:0] lo_data, hi_data;

    assign lo_data = inst_r[cfg_link_data_width_p-1:0];

    // hi part is zero-extended to the full link data width
    always_comb begin
        hi_data = '0;
        hi_data[hi_width_lp-1:0] =
            inst_r[inst_width_p-1:cfg_link_data_width_p];
    end

`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
    logic lo_match, hi_match;
    assign lo_match = (bus.config_data_i == lo_data);
    assign hi_match = (bus.config_data_i == hi_data);
`else
    logic unused_readback;
    assign unused_readback = ^{bus.config_data_i, bus.config_v_i};
`endif

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            RESET:   state_n = IDLE;
            IDLE:    if (start_i) state_n = ROM_RD;
            ROM_RD:  state_n = ROM_CAP;
            ROM_CAP: state_n = WR_LO;
            WR_LO:   if (bus.config_ready_i) state_n = WR_HI;
`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
            WR_HI:   if (bus.config_ready_i) state_n = RD_LO_REQ;
            RD_LO_REQ:
                if (bus.config_ready_i) state_n = RD_LO_RESP;
            RD_LO_RESP:
                if (bus.config_v_i)
                    state_n = lo_match ? RD_HI_REQ : ERROR;
            RD_HI_REQ:
                if (bus.config_ready_i) state_n = RD_HI_RESP;
            RD_HI_RESP:
                if (bus.config_v_i)
                    state_n = hi_match ? NEXT : ERROR;
`else
            WR_HI:   if (bus.config_ready_i) state_n = NEXT;
`endif
            NEXT:    state_n = (idx_r == last_idx_lp) ? DONE : ROM_RD;
            DONE:    state_n = DONE;
            ERROR:   state_n = ERROR;
            default: state_n = RESET;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= RESET;
            idx_r   <= '0;
            inst_r  <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && start_i)
                idx_r <= '0;
            else if (state_r == NEXT && idx_r != last_idx_lp)
                idx_r <= idx_r + 1'b1;
            if (state_r == ROM_CAP)
                inst_r <= bus.rom_data_i;
        end
    end

    logic is_wr_lo, is_wr_hi, is_rd_lo, is_rd_hi;
    assign is_wr_lo = (state_r == WR_LO);
    assign is_wr_hi = (state_r == WR_HI);
`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
    assign is_rd_lo = (state_r == RD_LO_REQ);
    assign is_rd_hi = (state_r == RD_HI_REQ);
    assign bus.config_ready_o = (state_r == RD_LO_RESP)
                              | (state_r == RD_HI_RESP);
    assign error_o = (state_r == ERROR);
`else
    assign is_rd_lo = 1'b0;
    assign is_rd_hi = 1'b0;
    assign bus.config_ready_o = 1'b0;
    assign error_o = 1'b0;
`endif

    assign bus.rom_v_o    = (state_r == ROM_RD);
    assign bus.rom_addr_o = idx_r;

    assign bus.config_v_o = is_wr_lo | is_wr_hi | is_rd_lo | is_rd_hi;
    assign bus.config_w_o = is_wr_lo | is_wr_hi;

    // msb selects the instruction RAM, bit 0 selects the hi half
    always_comb begin
        bus.config_addr_o = '0;
        bus.config_addr_o[cfg_addr_w_lp-1] = 1'b1;
        bus.config_addr_o[1 +: inst_addr_width_lp] = idx_r;
        bus.config_addr_o[0] = is_wr_hi | is_rd_hi;
    end

    always_comb begin
        bus.config_data_o = '0;
        if (is_wr_lo) bus.config_data_o = lo_data;
        if (is_wr_hi) bus.config_data_o = hi_data;
    end

    assign freeze_o = (state_r != DONE);
    assign done_o   = (state_r == DONE);

endmodule

// File: tb/tb_bp_cce_inst_ram_loader.sv
// Self-checking bench for bp_cce_inst_ram_loader: vector table plus write scoreboard.
module tb_bp_cce_inst_ram_loader;
    localparam int ELS = 4;
`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
    localparam int PER_ENTRY = 9;
    localparam bit VERIFY = 1'b1;
`else
    localparam int PER_ENTRY = 5;
    localparam bit VERIFY = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    logic start_i = 1'b0;
    logic freeze_o, done_o, error_o;

    bp_cce_inst_ram_loader_if #(
        .inst_ram_els_p(ELS), .inst_width_p(48),
        .cfg_link_addr_width_p(16), .cfg_link_data_width_p(32)
    ) bus ();

    bp_cce_inst_ram_loader #(
        .inst_ram_els_p(ELS), .inst_width_p(48),
        .cfg_link_addr_width_p(16), .cfg_link_data_width_p(32)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .bus(bus),
        .freeze_o(freeze_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [47:0] seed;
        int          stall_entry;
        int          stall_hi;
        int          stall_n;
        int          exp_cycles;
        int          exp_writes;
    } vec_t;

    int tests = 0;
    int fails = 0;
    wr_t sb[$];

    logic [47:0] rom [ELS];
    logic [31:0] mem [8];
    logic [2:0]  rd_addr = '0;
    logic        corrupt = 1'b0;
    logic        stall_arm = 1'b0;
    logic [14:0] stall_addr = '0;
    int          stall_n = 0;
    int          stall_cnt = 0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    int          writes = 0;
    logic [14:0] first_addr = '0;
    int          ready_o_bad = 0;
    logic [14:0] snap_addr;
    logic [31:0] snap_data;

    function automatic logic [14:0] exp_addr(int i, int hi);
        logic [14:0] a;
        a = '0;
        a[14] = 1'b1;
        a[2:1] = i[1:0];
        a[0] = hi[0];
        return a;
    endfunction

    function automatic logic [31:0] exp_data(logic [47:0] w, int hi);
        if (hi != 0) return {16'h0000, w[47:32]};
        return w[31:0];
    endfunction

    task automatic check(string n, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // target-side models: ROM, config RAM with stall and readback
    logic stalling;
    assign stalling = stall_arm && bus.config_v_o && bus.config_w_o
                   && bus.config_addr_o == stall_addr
                   && stall_cnt < stall_n;
    assign bus.config_ready_i = !stalling;
    assign bus.config_data_i = mem[rd_addr]
        ^ {31'b0, corrupt && rd_addr == 3'b001};
`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
    assign bus.config_v_i = bus.config_ready_o;
`else
    assign bus.config_v_i = 1'b1;
`endif

    always @(posedge clk_i) begin
        if (bus.rom_v_o) bus.rom_data_i <= rom[bus.rom_addr_o];
        if (!stall_arm) stall_cnt <= 0;
        else if (stalling) stall_cnt <= stall_cnt + 1;
        if (bus.config_v_o && bus.config_ready_i) begin
            if (bus.config_w_o) mem[bus.config_addr_o[2:0]] <= bus.config_data_o;
            else rd_addr <= bus.config_addr_o[2:0];
        end
    end

    always @(negedge clk_i) begin
        if (bus.config_v_o && bus.config_ready_i && bus.config_w_o) begin
            if (writes == 0) first_addr = bus.config_addr_o;
            writes++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.config_addr_o, bus.config_data_o);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(bus.config_addr_o), 64'(e.addr));
                check("wr_data", 64'(bus.config_data_o), 64'(e.data));
            end
        end
        if (stall_arm && stall_n > 0 && bus.config_v_o && bus.config_w_o
            && bus.config_addr_o == stall_addr) begin
            if (stall_seen == 0) begin
                snap_addr = bus.config_addr_o;
                snap_data = bus.config_data_o;
            end else if (bus.config_addr_o != snap_addr
                         || bus.config_data_o != snap_data)
                stall_bad++;
            stall_seen++;
        end
        if (!VERIFY && bus.config_ready_o) ready_o_bad++;
    end

    task automatic do_reset();
        #1 reset_i = 1'b1;
        stall_arm = 1'b0;
        corrupt = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        sb.delete();
        writes = 0;
        stall_seen = 0;
        stall_bad = 0;
    endtask

    task automatic fill_rom(logic [47:0] seed);
        for (int i = 0; i < ELS; i++)
            rom[i] = seed + 48'h0103_0507_090b * 48'(i);
    endtask

    task automatic push_expected();
        for (int i = 0; i < ELS; i++) begin
            sb.push_back('{exp_addr(i, 0), exp_data(rom[i], 0)});
            sb.push_back('{exp_addr(i, 1), exp_data(rom[i], 1)});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_end(string n, output int cycles);
        cycles = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_i);
            if (!freeze_o || error_o) return;
            cycles++;
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: got no done/error expected one within 1000 cycles", n);
    endtask

    vec_t vecs[4];

    initial begin
        int cyc;
        logic quiet;

        vecs[0] = '{"plain", 48'h1234_5678_9abc, 0, 0, 0,
                    ELS * PER_ENTRY, 2 * ELS};
        vecs[1] = '{"stall_e1_lo", 48'hdead_beef_0001, 1, 0, 3,
                    ELS * PER_ENTRY + 3, 2 * ELS};
        vecs[2] = '{"stall_e3_hi", 48'h0f0f_a5a5_5a5a, 3, 1, 2,
                    ELS * PER_ENTRY + 2, 2 * ELS};
        vecs[3] = '{"ones", 48'hffff_ffff_ffff, 0, 0, 0,
                    ELS * PER_ENTRY, 2 * ELS};

        // reset state, sampled while reset is held
        #1 reset_i = 1'b1;
        #3;
        check("rst_freeze", 64'(freeze_o), 64'd1);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_cfg_v", 64'(bus.config_v_o), 64'd0);
        check("rst_rom_v", 64'(bus.rom_v_o), 64'd0);
        check("rst_ready_o", 64'(bus.config_ready_o), 64'd0);
        do_reset();
        repeat (3) @(negedge clk_i);
        check("idle_freeze", 64'(freeze_o), 64'd1);
        check("idle_cfg_v", 64'(bus.config_v_o), 64'd0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            fill_rom(vecs[v].seed);
            stall_addr = exp_addr(vecs[v].stall_entry, vecs[v].stall_hi);
            stall_n = vecs[v].stall_n;
            stall_arm = 1'b1;
            push_expected();
            pulse_start();
            wait_end(vecs[v].name, cyc);
            check({vecs[v].name, "_cycles"}, 64'(cyc), 64'(vecs[v].exp_cycles));
            check({vecs[v].name, "_done"}, 64'(done_o), 64'd1);
            check({vecs[v].name, "_error"}, 64'(error_o), 64'd0);
            check({vecs[v].name, "_writes"}, 64'(writes), 64'(vecs[v].exp_writes));
            check({vecs[v].name, "_sb_left"}, 64'(sb.size()), 64'd0);
            if (vecs[v].stall_n > 0) begin
                check({vecs[v].name, "_held"}, 64'(stall_seen),
                      64'(vecs[v].stall_n + 1));
                check({vecs[v].name, "_stable"}, 64'(stall_bad), 64'd0);
            end
        end
        check("ready_o_idle", 64'(ready_o_bad), 64'd0);

        // reset in the middle of entry 2's hi write
        do_reset();
        fill_rom(48'h0aa0_5115_7ee7);
        push_expected();
        pulse_start();
        quiet = 1'b0;
        for (int k = 0; k < 200 && !quiet; k++) begin
            @(negedge clk_i);
            if (bus.config_v_o && bus.config_w_o
                && bus.config_addr_o == exp_addr(2, 1)) quiet = 1'b1;
        end
        check("mid_reached_e2_hi", 64'(quiet), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        check("mid_rst_cfg_v", 64'(bus.config_v_o), 64'd0);
        check("mid_rst_rom_v", 64'(bus.rom_v_o), 64'd0);
        check("mid_rst_freeze", 64'(freeze_o), 64'd1);
        check("mid_rst_done", 64'(done_o), 64'd0);
        check("mid_rst_error", 64'(error_o), 64'd0);
        do_reset();
        push_expected();
        pulse_start();
        wait_end("restart", cyc);
        check("restart_first_addr", 64'(first_addr), 64'(exp_addr(0, 0)));
        check("restart_done", 64'(done_o), 64'd1);
        check("restart_writes", 64'(writes), 64'(2 * ELS));

        // start held high through DONE
        do_reset();
        fill_rom(48'h3141_5926_5358);
        push_expected();
        @(posedge clk_i);
        #1 start_i = 1'b1;
        wait_end("held", cyc);
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk_i);
            if (!done_o || bus.config_v_o || freeze_o) quiet = 1'b0;
        end
        start_i = 1'b0;
        check("held_stays_done", 64'(quiet), 64'd1);
        check("held_writes", 64'(writes), 64'(2 * ELS));

`ifdef BP_CCE_INST_RAM_LOADER_VERIFY_EN
        // readback of entry 0 hi corrupted in bit 0
        do_reset();
        fill_rom(48'h2718_2818_2845);
        push_expected();
        corrupt = 1'b1;
        pulse_start();
        wait_end("verr", cyc);
        check("verr_error", 64'(error_o), 64'd1);
        check("verr_freeze", 64'(freeze_o), 64'd1);
        check("verr_done", 64'(done_o), 64'd0);
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (bus.config_v_o || !error_o || !freeze_o) quiet = 1'b0;
        end
        check("verr_quiet", 64'(quiet), 64'd1);
        check("verr_writes", 64'(writes), 64'd2);
        sb.delete();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
